s_axis_pkt_buffer: RTL and testbench
====================================

S_AXIS_PKT_BUFFER -- requirements
Module: s_axis_pkt_buffer

Interface
REQ-001 Parameters SHALL be:
  - DATA_BYTES, 4: stream width in bytes; tdata = 8*DATA_BYTES bits.
  - SLOT_BYTES, 1024: byte capacity of each packet slot.
  - NUM_SLOTS, 2: packet slots, power of 2, at least 2.
  - LEN_W, 16: length field width; must satisfy 2^LEN_W > SLOT_BYTES.
REQ-002 The design SHALL have one clock, aclk; reset aresetn is synchronous and active-low.
REQ-003 Ports SHALL be (name, direction, width, meaning):
  - aclk, in, 1: clock.
  - aresetn, in, 1: synchronous active-low reset.
  - s_axis_tdata, in, 8*DATA_BYTES: stream data.
  - s_axis_tkeep, in, DATA_BYTES: byte enables.
  - s_axis_tvalid, in, 1: beat valid.
  - s_axis_tlast, in, 1: last beat of packet.
  - s_axis_tready, out, 1: beat accepted when high with tvalid.
  - flush, in, 1: rising edge discards all stored and in-progress data.
  - pkt_ready, out, 1: head slot holds a committed packet.
  - pkt_len, out, LEN_W: byte count of head packet.
  - pkt_trunc, out, 1: head packet was truncated.
  - pkt_release, in, 1: one-cycle pulse that frees the head slot.
  - rd_addr, in, LEN_W: byte index into the head slot.
  - rd_data, out, 8: byte at rd_addr of the head slot, one cycle later.
  - trunc_count, out, 16: number of truncated packets, saturating.

Function
REQ-004 Slots SHALL form a ring with a write pointer wr_ptr and read pointer rd_ptr, both wrapping modulo NUM_SLOTS; valid[i] marks committed slot i.
REQ-005 The write FSM SHALL have three states:
  - IDLE to FILL on an accepted beat.
  - FILL to IDLE on an accepted tlast beat.
  - FILL to DRAIN on overflow.
  - DRAIN to IDLE on an accepted tlast beat.
REQ-006 s_axis_tready SHALL be high in IDLE/FILL when valid[wr_ptr]==0, and always high in DRAIN.
REQ-007 Each byte i with tkeep[i]=1 SHALL be written to address wr_len + popcount(tkeep[i-1:0]), so sparse keeps are packed; wr_len then increases by popcount(tkeep).
REQ-008 A beat with tkeep==0 SHALL be accepted with no bytes written; if it carries tlast, it still terminates the packet.
REQ-009 Overflow: if a beat's bytes exceed SLOT_BYTES - wr_len:
  - only the bytes that fit are stored and wr_len becomes SLOT_BYTES;
  - the slot is marked truncated and trunc_count increments (saturating at 16'hFFFF);
  - if the beat lacks tlast, the FSM enters DRAIN, which accepts and discards beats until tlast.
REQ-010 Commit SHALL happen on the accepted tlast beat:
  - valid[wr_ptr], len and trunc are registered;
  - wr_ptr advances;
  - pkt_ready rises on the cycle after that beat;
  - wr_len clears.
REQ-011 A packet ending in DRAIN SHALL commit the slot on the tlast beat with len = SLOT_BYTES and trunc = 1.
REQ-012 pkt_ready SHALL equal valid[rd_ptr]; pkt_len and pkt_trunc SHALL reflect slot rd_ptr and are don't-care when pkt_ready=0.
REQ-013 pkt_release with pkt_ready=1 SHALL clear valid[rd_ptr] and advance rd_ptr on the next edge; pkt_release with pkt_ready=0 SHALL be ignored.
REQ-014 A commit and a release on the same cycle SHALL both take effect; when the ring is full, the freed slot becomes writable on the next cycle.
REQ-015 rd_data SHALL be registered with one-cycle latency; reads at rd_addr >= pkt_len return an undefined byte.
REQ-016 A rising edge of flush (flush=1 while the previous sample was 0) SHALL, on the next edge:
  - clear all valid bits, both pointers and wr_len;
  - send the FSM to DRAIN if mid-packet (state FILL, or the current beat lacks tlast), else to IDLE.
  Flush SHALL NOT clear trunc_count, and the beat coincident with flush SHALL be discarded.
REQ-017 Storage SHALL be a single byte-wide RAM of NUM_SLOTS*SLOT_BYTES entries; slot contents are not cleared by reset or flush.

Reset
REQ-018 With aresetn=0 at an edge, the block SHALL set:
  - state=IDLE;
  - wr_ptr=rd_ptr=0, valid=0, wr_len=0;
  - trunc_count=0, pkt_ready=0, pkt_len=0, pkt_trunc=0, rd_data=0;
  - the flush edge register to 0.
  s_axis_tready SHALL be 0 while aresetn=0.
REQ-019 Reset asserted mid-packet SHALL discard that packet; after release, a new packet starts at wr_len=0.

Verification
REQ-020 A bench SHALL cover these scenarios:
  - 3 full beats then tkeep=4'b0011 with tlast -> pkt_ready=1 one cycle later, pkt_len=14, pkt_trunc=0, bytes 0..13 readable in order.
  - tkeep=4'b1010 on one beat with tlast, data 0xDDCCBBAA -> pkt_len=2, byte0=0xBB, byte1=0xDD.
  - SLOT_BYTES=8, 4-beat packet of 16 bytes -> tready stays 1, pkt_len=8, pkt_trunc=1, trunc_count=1.
  - NUM_SLOTS=2, two packets with no release -> tready=0 on the third tvalid; pkt_release the same cycle as the third packet's tlast -> ring stays consistent and the third packet commits to slot 0.
  - flush pulse during beat 2 of a 4-beat packet -> pkt_ready=0, remaining beats consumed, next packet has pkt_len counted from 0.
  - aresetn=0 for one cycle mid-packet -> all outputs at reset values; the following packet stores correctly in slot 0.

Source files
------------

// File: rtl/s_axis_pkt_buffer.sv
// AXI-Stream packet buffer.
// Incoming packets are packed byte-wise into a ring of fixed-size slots held in
// one byte-wide RAM. A packet becomes visible at the head once its tlast beat
// has been accepted. Packets longer than a slot are truncated, and the rest of
// the packet is drained. A rising edge on flush empties the whole ring.
module s_axis_pkt_buffer #(
  parameter int DATA_BYTES = 4,
  parameter int SLOT_BYTES = 1024,
  parameter int NUM_SLOTS  = 2,
  parameter int LEN_W      = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [8*DATA_BYTES-1:0] s_axis_tdata,
  input  logic [DATA_BYTES-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  input  logic                    flush,
  output logic                    pkt_ready,
  output logic [LEN_W-1:0]        pkt_len,
  output logic                    pkt_trunc,
  input  logic                    pkt_release,
  input  logic [LEN_W-1:0]        rd_addr,
  output logic [7:0]              rd_data,
  output logic [15:0]             trunc_count
);

  localparam int PTR_W  = $clog2(NUM_SLOTS);
  localparam int DEPTH  = NUM_SLOTS * SLOT_BYTES;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DRAIN} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [NUM_SLOTS-1:0] valid, valid_nxt;
  logic [LEN_W-1:0]   wr_len;
  logic [LEN_W-1:0]   slot_len [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_trunc;
  logic               flush_q;
  logic               drain_discard;
  logic [7:0]         mem [DEPTH];

  // Handshake and control qualifiers
  logic               accept, flush_rise, take, fill_beat, commit, release_fire, mid_pkt;
  int                 beat_bytes, room, off;
  logic               overflow;
  logic [LEN_W-1:0]   commit_len;
  logic               commit_trunc;
  logic               we    [DATA_BYTES];
  logic [ADDR_W-1:0]  waddr [DATA_BYTES];
  logic [ADDR_W-1:0]  raddr;
  logic               rd_in_slot;

  assign accept       = s_axis_tvalid && s_axis_tready;
  assign flush_rise   = flush && !flush_q;
  // The beat coincident with a flush edge is swallowed.
  assign take         = accept && !flush_rise;
  assign fill_beat    = take && (state != ST_DRAIN);
  // A drain started by flush belongs to a discarded packet and never commits.
  assign commit       = take && s_axis_tlast && !((state == ST_DRAIN) && drain_discard);
  assign release_fire = pkt_release && valid[rd_ptr] && !flush_rise;
  assign mid_pkt      = (state == ST_FILL) ||
                        ((state == ST_DRAIN) && !(accept && s_axis_tlast)) ||
                        ((state == ST_IDLE) && accept && !s_axis_tlast);

  // Beat byte count, overflow detection and packed byte write addresses
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    beat_bytes = 0;
    off        = int'(wr_len);
    for (int i = 0; i < DATA_BYTES; i++) begin
      beat_bytes = beat_bytes + int'(s_axis_tkeep[i]);
    end
    room         = SLOT_BYTES - int'(wr_len);
    overflow     = fill_beat && (beat_bytes > room);
    commit_trunc = (state == ST_DRAIN) || overflow;
    commit_len   = commit_trunc ? LEN_W'(SLOT_BYTES) : LEN_W'(int'(wr_len) + beat_bytes);
    for (int i = 0; i < DATA_BYTES; i++) begin
      we[i]    = 1'b0;
      waddr[i] = '0;
      if (fill_beat && s_axis_tkeep[i] && (off < SLOT_BYTES)) begin
        we[i]    = 1'b1;
        waddr[i] = ADDR_W'(int'(wr_ptr) * SLOT_BYTES + off);
      end
      if (s_axis_tkeep[i]) off = off + 1;
    end
  end

  // Write FSM state register
  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Write FSM next-state logic
  always_comb begin
    state_nxt = state;
    if (flush_rise) begin
      state_nxt = mid_pkt ? ST_DRAIN : ST_IDLE;
    end else if (accept) begin
      case (state)
        ST_IDLE, ST_FILL: begin
          if (s_axis_tlast)  state_nxt = ST_IDLE;
          else if (overflow) state_nxt = ST_DRAIN;
          else               state_nxt = ST_FILL;
        end
        ST_DRAIN: if (s_axis_tlast) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Write FSM outputs: draining never back-pressures, filling needs a free slot
  always_comb begin
    s_axis_tready = aresetn && ((state == ST_DRAIN) || !valid[wr_ptr]);
  end

  // Slot occupancy after this cycle's commit and release
  always_comb begin
    valid_nxt = valid;
    if (commit)       valid_nxt[wr_ptr] = 1'b1;
    if (release_fire) valid_nxt[rd_ptr] = 1'b0;
  end

  // Ring pointers, occupancy, fill length and flush edge tracking
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      valid         <= '0;
      wr_len        <= '0;
      flush_q       <= 1'b0;
      drain_discard <= 1'b0;
    end else begin
      flush_q <= flush;
      if (flush_rise) begin
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        valid         <= '0;
        wr_len        <= '0;
        drain_discard <= mid_pkt;
      end else begin
        valid <= valid_nxt;
        if (commit)       wr_ptr <= wr_ptr + PTR_W'(1);
        if (release_fire) rd_ptr <= rd_ptr + PTR_W'(1);
        if (take && s_axis_tlast) begin
          wr_len        <= '0;
          drain_discard <= 1'b0;
        end else if (fill_beat) begin
          wr_len <= overflow ? LEN_W'(SLOT_BYTES) : LEN_W'(int'(wr_len) + beat_bytes);
        end
      end
    end
  end

  // Per-slot packet descriptors and the saturating truncation counter
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_SLOTS; i++) slot_len[i] <= '0;
      slot_trunc  <= '0;
      trunc_count <= '0;
    end else begin
      if (commit) begin
        slot_len[wr_ptr]   <= commit_len;
        slot_trunc[wr_ptr] <= commit_trunc;
      end
      if (overflow && (trunc_count != 16'hFFFF)) trunc_count <= trunc_count + 16'd1;
    end
  end

  // Packet RAM write port
  always_ff @(posedge aclk) begin
    // NOTE: the packet RAM has no reset; contents are only meaningful below a committed length.
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (we[i]) mem[waddr[i]] <= s_axis_tdata[8*i +: 8];
    end
  end

  assign rd_in_slot = int'(rd_addr) < SLOT_BYTES;
  assign raddr      = ADDR_W'(int'(rd_ptr) * SLOT_BYTES + (rd_in_slot ? int'(rd_addr) : 0));

  // Registered head-slot byte read
  always_ff @(posedge aclk) begin
    if (!aresetn) rd_data <= 8'h00;
    else          rd_data <= mem[raddr];
  end

  assign pkt_ready = valid[rd_ptr];
  assign pkt_len   = slot_len[rd_ptr];
  assign pkt_trunc = slot_trunc[rd_ptr];

endmodule

// File: tb/tb_s_axis_pkt_buffer.sv
// Self-checking bench for s_axis_pkt_buffer. Two instances share stimulus:
// a default-sized one and one with 8-byte slots for truncation. Expected
// packets are pushed to a scoreboard as beats are built and popped when the
// head packet is read back.
module tb_s_axis_pkt_buffer;

  typedef struct {
    int         len;
    logic       trunc;
    logic [7:0] data [64];
  } pkt_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid, tlast, flush, pkt_release, use_small;
  logic [15:0] rd_addr;

  logic        b_tready, b_pkt_ready, b_pkt_trunc;
  logic [15:0] b_pkt_len, b_trunc_count;
  logic [7:0]  b_rd_data;
  logic        s_tready, s_pkt_ready, s_pkt_trunc;
  logic [15:0] s_pkt_len, s_trunc_count;
  logic [7:0]  s_rd_data;

  logic        cur_tready, cur_pkt_ready, cur_pkt_trunc;
  logic [15:0] cur_pkt_len;
  logic [7:0]  cur_rd_data;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          stall_cycles;
  logic [31:0] bd [16];
  logic [3:0]  bk [16];
  pkt_t        sb [$];

  always #5 aclk = ~aclk;

  s_axis_pkt_buffer #(.DATA_BYTES(4), .SLOT_BYTES(1024), .NUM_SLOTS(2), .LEN_W(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid && !use_small),
    .s_axis_tlast(tlast), .s_axis_tready(b_tready),
    .flush(flush && !use_small), .pkt_ready(b_pkt_ready), .pkt_len(b_pkt_len),
    .pkt_trunc(b_pkt_trunc), .pkt_release(pkt_release && !use_small),
    .rd_addr(rd_addr), .rd_data(b_rd_data), .trunc_count(b_trunc_count)
  );

  s_axis_pkt_buffer #(.DATA_BYTES(4), .SLOT_BYTES(8), .NUM_SLOTS(2), .LEN_W(16)) dut_small (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid && use_small),
    .s_axis_tlast(tlast), .s_axis_tready(s_tready),
    .flush(flush && use_small), .pkt_ready(s_pkt_ready), .pkt_len(s_pkt_len),
    .pkt_trunc(s_pkt_trunc), .pkt_release(pkt_release && use_small),
    .rd_addr(rd_addr), .rd_data(s_rd_data), .trunc_count(s_trunc_count)
  );

  assign cur_tready    = use_small ? s_tready    : b_tready;
  assign cur_pkt_ready = use_small ? s_pkt_ready : b_pkt_ready;
  assign cur_pkt_len   = use_small ? s_pkt_len   : b_pkt_len;
  assign cur_pkt_trunc = use_small ? s_pkt_trunc : b_pkt_trunc;
  assign cur_rd_data   = use_small ? s_rd_data   : b_rd_data;

  // Fill nb full beats with an incrementing byte pattern starting at seed.
  task automatic fill_beats(input int nb, input int seed);
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < 4; i++) bd[b][8*i +: 8] = 8'(seed + 4*b + i);
      bk[b] = 4'hF;
    end
  endtask

  // Reference model: pack kept bytes in order, cut at the slot capacity.
  task automatic model_push(input int nb, input int cap);
    pkt_t p;
    p.len   = 0;
    p.trunc = 1'b0;
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < 4; i++) begin
        if (bk[b][i]) begin
          if (p.len < cap) begin
            p.data[p.len] = bd[b][8*i +: 8];
            p.len++;
          end else begin
            p.trunc = 1'b1;
          end
        end
      end
    end
    sb.push_back(p);
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int waited = 0;
    tdata = d; tkeep = k; tlast = l; tvalid = 1'b1;
    #1;
    while (!cur_tready && waited < 50) begin
      @(negedge aclk);
      waited++;
    end
    stall_cycles += waited;
    tests_run++;
    if (cur_tready !== 1'b1) begin
      tests_failed++;
      $display("FAIL beat_accept_timeout: tready got %b expected 1 after %0d cycles", cur_tready, waited);
    end else begin
      @(negedge aclk);
    end
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic send_pkt(input int nb, input int cap);
    model_push(nb, cap);
    for (int b = 0; b < nb; b++) drive_beat(bd[b], bk[b], b == nb - 1);
  endtask

  // Pop the expected head packet and compare descriptor and every byte.
  task automatic check_head(input string name);
    pkt_t e;
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $display("FAIL %s_scoreboard: got empty queue expected a packet", name);
      return;
    end
    e = sb.pop_front();
    tests_run++;
    if (cur_pkt_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_ready: got %b expected 1", name, cur_pkt_ready);
    end
    tests_run++;
    if (cur_pkt_len !== 16'(e.len)) begin
      tests_failed++;
      $display("FAIL %s_len: got %0d expected %0d", name, cur_pkt_len, e.len);
    end
    tests_run++;
    if (cur_pkt_trunc !== e.trunc) begin
      tests_failed++;
      $display("FAIL %s_trunc: got %b expected %b", name, cur_pkt_trunc, e.trunc);
    end
    for (int i = 0; i < e.len; i++) begin
      rd_addr = 16'(i);
      @(negedge aclk);
      tests_run++;
      if (cur_rd_data !== e.data[i]) begin
        tests_failed++;
        $display("FAIL %s_byte%0d: got %02h expected %02h", name, i, cur_rd_data, e.data[i]);
      end
    end
  endtask

  task automatic release_head();
    pkt_release = 1'b1;
    @(negedge aclk);
    pkt_release = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    tests_run++;
    if ({b_tready, s_tready} !== 2'b00) begin
      tests_failed++;
      $display("FAIL rst_tready: got %b expected 00", {b_tready, s_tready});
    end
    tests_run++;
    if ({b_pkt_ready, b_pkt_trunc, b_pkt_len, b_rd_data, b_trunc_count} !== 50'd0) begin
      tests_failed++;
      $display("FAIL rst_outputs: got rdy=%b trunc=%b len=%0d data=%02h cnt=%0d expected all 0",
               b_pkt_ready, b_pkt_trunc, b_pkt_len, b_rd_data, b_trunc_count);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    tests_run++;
    if (b_tready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_release_tready: got %b expected 1", b_tready);
    end
  endtask

  task automatic test_multi_beat();
    fill_beats(4, 0);
    bk[3] = 4'b0011;
    model_push(4, 1024);
    for (int b = 0; b < 3; b++) drive_beat(bd[b], bk[b], 1'b0);
    tests_run++;
    if (cur_pkt_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL mb_ready_early: got %b expected 0", cur_pkt_ready);
    end
    drive_beat(bd[3], bk[3], 1'b1);
    tests_run++;
    if (cur_pkt_len !== 16'd14) begin
      tests_failed++;
      $display("FAIL mb_len14: got %0d expected 14", cur_pkt_len);
    end
    check_head("mb");
    release_head();
    tests_run++;
    if (cur_pkt_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL mb_released: got %b expected 0", cur_pkt_ready);
    end
  endtask

  task automatic test_sparse_keep();
    bd[0] = 32'hDDCCBBAA;
    bk[0] = 4'b1010;
    send_pkt(1, 1024);
    tests_run++;
    if ({cur_pkt_len, cur_rd_data} === 24'h0002BB) begin end
    if (cur_pkt_len !== 16'd2) begin
      tests_failed++;
      $display("FAIL sparse_len: got %0d expected 2", cur_pkt_len);
    end
    check_head("sparse");
    release_head();
  endtask

  task automatic test_overflow();
    use_small = 1'b1;
    fill_beats(4, 8'h40);
    stall_cycles = 0;
    send_pkt(4, 8);
    tests_run++;
    if (stall_cycles !== 0) begin
      tests_failed++;
      $display("FAIL ovf_no_stall: got %0d stall cycles expected 0", stall_cycles);
    end
    tests_run++;
    if (s_trunc_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL ovf_trunc_count: got %0d expected 1", s_trunc_count);
    end
    check_head("ovf");
    release_head();
    fill_beats(1, 8'h60);
    send_pkt(1, 8);
    check_head("ovf_next");
    release_head();
    use_small = 1'b0;
  endtask

  task automatic test_ring_full();
    fill_beats(1, 8'h10);
    send_pkt(1, 1024);
    fill_beats(1, 8'h20);
    send_pkt(1, 1024);
    fill_beats(2, 8'h80);
    model_push(2, 1024);
    tdata = bd[0]; tkeep = bk[0]; tlast = 1'b0; tvalid = 1'b1;
    #1;
    tests_run++;
    if (cur_tready !== 1'b0) begin
      tests_failed++;
      $display("FAIL ring_full_tready: got %b expected 0", cur_tready);
    end
    check_head("ring_a");
    tests_run++;
    if (cur_tready !== 1'b0) begin
      tests_failed++;
      $display("FAIL ring_still_full: got %b expected 0", cur_tready);
    end
    release_head();
    tests_run++;
    if (cur_tready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ring_freed_tready: got %b expected 1", cur_tready);
    end
    @(negedge aclk);
    tvalid = 1'b0;
    check_head("ring_b");
    tdata = bd[1]; tkeep = bk[1]; tlast = 1'b1; tvalid = 1'b1;
    pkt_release = 1'b1;
    #1;
    tests_run++;
    if (cur_tready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ring_c_last_tready: got %b expected 1", cur_tready);
    end
    @(negedge aclk);
    tvalid = 1'b0; tlast = 1'b0; pkt_release = 1'b0;
    check_head("ring_c");
    release_head();
    tests_run++;
    if ({cur_pkt_ready, cur_tready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL ring_empty: got ready/tready %b expected 01", {cur_pkt_ready, cur_tready});
    end
  endtask

  task automatic test_zero_keep();
    fill_beats(1, 8'h30);
    bd[1] = 32'hFFFFFFFF;
    bk[1] = 4'b0000;
    send_pkt(2, 1024);
    check_head("zkeep");
    release_head();
  endtask

  task automatic test_flush();
    fill_beats(1, 8'h90);
    send_pkt(1, 1024);
    fill_beats(4, 8'hA0);
    drive_beat(bd[0], bk[0], 1'b0);
    tdata = bd[1]; tkeep = bk[1]; tlast = 1'b0; tvalid = 1'b1; flush = 1'b1;
    @(negedge aclk);
    tvalid = 1'b0; flush = 1'b0;
    sb.delete();
    tests_run++;
    if (cur_pkt_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_ready: got %b expected 0", cur_pkt_ready);
    end
    stall_cycles = 0;
    drive_beat(bd[2], bk[2], 1'b0);
    drive_beat(bd[3], bk[3], 1'b1);
    tests_run++;
    if ({cur_pkt_ready, 8'(stall_cycles)} !== 9'd0) begin
      tests_failed++;
      $display("FAIL flush_drain: got ready=%b stalls=%0d expected 0/0", cur_pkt_ready, stall_cycles);
    end
    fill_beats(2, 8'hC0);
    bk[1] = 4'b0111;
    send_pkt(2, 1024);
    check_head("flush_next");
    release_head();
  endtask

  task automatic test_reset_mid();
    fill_beats(1, 8'hE0);
    send_pkt(1, 1024);
    fill_beats(2, 8'h50);
    drive_beat(bd[0], bk[0], 1'b0);
    aresetn = 1'b0;
    #1;
    tests_run++;
    if (b_tready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_tready: got %b expected 0", b_tready);
    end
    @(negedge aclk);
    tests_run++;
    if ({b_pkt_ready, b_pkt_trunc, b_pkt_len, b_rd_data, b_trunc_count, s_trunc_count} !== 66'd0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: got rdy=%b trunc=%b len=%0d data=%02h cnt=%0d scnt=%0d expected all 0",
               b_pkt_ready, b_pkt_trunc, b_pkt_len, b_rd_data, b_trunc_count, s_trunc_count);
    end
    aresetn = 1'b1;
    sb.delete();
    fill_beats(1, 8'h70);
    send_pkt(1, 1024);
    check_head("rstmid_next");
    release_head();
  endtask

  initial begin
    aresetn = 1'b0; tdata = '0; tkeep = '0; tvalid = 1'b0; tlast = 1'b0;
    flush = 1'b0; pkt_release = 1'b0; rd_addr = '0; use_small = 1'b0; stall_cycles = 0;
    test_reset();
    test_multi_beat();
    test_sparse_keep();
    test_overflow();
    test_ring_full();
    test_zero_keep();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
